// File: rtl/n2_dva_dp_regfile_param.sv
// Parametrised 1R1W register file with per-bit write enables, optional
// write-to-read bypass, a clear-on-reset sweep and out-of-range detection.
module n2_dva_dp_regfile_param #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned BYPASS = 1
) (
    input  logic             l2clk,
    input  logic             arst_l,
    input  logic             tcu_array_wr_inhibit,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] bit_wen,
    output logic [WIDTH-1:0] dout,
    output logic             init_busy,
    output logic             addr_err
);

    typedef enum logic {INIT, READY} state_t;

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    state_t          state, state_nxt;
    logic [AW-1:0]   ptr, ptr_nxt;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             ready;
    logic             rd_ok, wr_ok, wr_q, err_nxt;
    logic [WIDTH-1:0] wr_old, wr_merged, rd_data;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            INIT: begin
                ptr_nxt = ptr + AW'(1);
                if (ptr == LAST) begin
                    state_nxt = READY;
                    ptr_nxt   = '0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        ready     = (state == READY);
        rd_ok     = ({1'b0, rd_addr} < DEPTH_W);
        wr_ok     = ({1'b0, wr_addr} < DEPTH_W);
        wr_q      = ready && wr_en && !tcu_array_wr_inhibit && wr_ok;
        wr_old    = mem[wr_addr];
        wr_merged = (wr_old & ~bit_wen) | (din & bit_wen);
        rd_data   = '0;
        // Only a qualifying write is forwarded, so inhibited writes never bypass.
        if (rd_ok) begin
            if ((BYPASS != 0) && wr_q && (wr_addr == rd_addr))
                rd_data = wr_merged;
            else
                rd_data = mem[rd_addr];
        end
        err_nxt   = ready && ((rd_en && !rd_ok) || (wr_en && !wr_ok));
    end

    always_ff @(posedge l2clk) begin
        if (state == INIT)
            mem[ptr] <= '0;
        else if (wr_q)
            mem[wr_addr] <= wr_merged;
    end

    always_ff @(posedge l2clk or negedge arst_l) begin
        if (!arst_l) begin
            state    <= INIT;
            ptr      <= '0;
            dout     <= '0;
            addr_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            addr_err <= err_nxt;
            if (ready && rd_en)
                dout <= rd_data;
        end
    end

    assign init_busy = (state == INIT);

endmodule
